// File: rtl/vx_decode_sched_tracker_pkg.sv
// rtl/vx_decode_sched_tracker_pkg.sv - shared warp state type and width helper
package vx_decode_sched_tracker_pkg;

  typedef enum logic [1:0] {
    WS_ACTIVE  = 2'd0,
    WS_BRANCH  = 2'd1,
    WS_BARRIER = 2'd2,
    WS_EXIT    = 2'd3
  } warp_state_t;

  // Index width for n items, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_decode_sched_tracker_rr_arbiter.sv
// rtl/vx_decode_sched_tracker_rr_arbiter.sv - round-robin pick over pending unlocks, locked while stalled
module vx_decode_sched_tracker_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [IDX_W-1:0]    idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;

  assign valid_o = |req_i;
  // A grant the scheduler has not yet taken must not move, even if new requests appear.
  assign idx_o   = hold_q ? hold_idx_q : pick;

  // First requester at or after the pointer, wrapping; scanned downward so the nearest wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQS);
      if (req_i[cand]) pick = cand;
    end
  end

  // Pointer advances past the accepted index; lock state tracks an unaccepted offer.
  always_comb begin
    ptr_d      = ptr_q;
    hold_d     = valid_o && !ready_i;
    hold_idx_d = idx_o;
    if (valid_o && ready_i) begin
      ptr_d = (idx_o == IDX_W'(NUM_REQS - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // Pointer and lock registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule

// File: rtl/vx_decode_sched_tracker.sv
// rtl/vx_decode_sched_tracker.sv - multi-lane decode feedback tracker with round-robin unlock notify
module vx_decode_sched_tracker
  import vx_decode_sched_tracker_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int STALL_CNT_W  = 2,
  parameter int NW_WIDTH     = clog2_min1(NUM_WARPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CHANNELS-1:0]          in_valid,
  input  logic [NUM_CHANNELS*NW_WIDTH-1:0] in_wid,
  input  logic [NUM_CHANNELS-1:0]          in_stall,
  input  logic [NUM_CHANNELS-1:0]          in_unlock,
  input  logic [NUM_CHANNELS-1:0]          in_rvc,
  input  logic [NUM_CHANNELS*2-1:0]        in_next_state,
  output logic [NUM_WARPS-1:0]         stalled_mask,
  output logic [NUM_WARPS-1:0]         rvc_mask,
  output logic [NUM_WARPS*2-1:0]       warp_state,
  output logic                         unlock_valid,
  output logic [NW_WIDTH-1:0]          unlock_wid,
  input  logic                         unlock_ready,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  // Signed width that holds count plus the worst-case per-cycle delta without wrapping.
  localparam int DW = STALL_CNT_W + clog2_min1(NUM_CHANNELS) + 1;
  localparam logic signed [DW-1:0] ONE_S     = DW'(1);
  localparam logic signed [DW-1:0] ZERO_S    = '0;
  localparam logic signed [DW-1:0] CNT_MAX_S = DW'((1 << STALL_CNT_W) - 1);

  logic [NUM_WARPS-1:0] pending_q, pending_d;
  logic [NUM_WARPS-1:0] pend_set, pend_clr;
  logic [NUM_WARPS-1:0] ovf_vec, udf_vec;
  logic                 ovf_q, udf_q;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   rvc_q, rvc_d;
    warp_state_t            state_q, state_d;
    logic                   ovf, udf;
    logic signed [DW-1:0]   sum;

    // Fold every valid lane aimed at this warp; later lanes override rvc/state.
    always_comb begin
      sum     = $signed({{(DW-STALL_CNT_W){1'b0}}, cnt_q});
      rvc_d   = rvc_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf     = 1'b0;
      udf     = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (in_valid[c] && (in_wid[c*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w))) begin
          if (in_stall[c])  sum = sum + ONE_S;
          if (in_unlock[c]) sum = sum - ONE_S;
          rvc_d = in_rvc[c];
          if (state_q != WS_EXIT) state_d = warp_state_t'(in_next_state[c*2 +: 2]);
        end
      end
      if (sum > CNT_MAX_S) begin
        cnt_d = '1;
        ovf   = 1'b1;
      end else if (sum < ZERO_S) begin
        cnt_d = '0;
        udf   = 1'b1;
      end else begin
        cnt_d = sum[STALL_CNT_W-1:0];
      end
    end

    // Per-warp counter, rvc flag and state registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        rvc_q   <= 1'b0;
        state_q <= WS_ACTIVE;
      end else begin
        cnt_q   <= cnt_d;
        rvc_q   <= rvc_d;
        state_q <= state_d;
      end
    end

    assign pend_set[w]           = (cnt_q != '0) && (cnt_d == '0);
    assign ovf_vec[w]            = ovf;
    assign udf_vec[w]            = udf;
    assign stalled_mask[w]       = (cnt_q != '0);
    assign rvc_mask[w]           = rvc_q;
    assign warp_state[w*2 +: 2]  = state_q;
  end

  // Accepted notification clears its bit; a fresh drain to zero in the same cycle re-arms it.
  always_comb begin
    pend_clr  = '0;
    if (unlock_valid && unlock_ready) pend_clr = NUM_WARPS'(1) << unlock_wid;
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // Pending bits and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_q | (|ovf_vec);
      udf_q     <= udf_q | (|udf_vec);
    end
  end

  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

  vx_decode_sched_tracker_rr_arbiter #(
    .NUM_REQS (NUM_WARPS),
    .IDX_W    (NW_WIDTH)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_i   (pending_q),
    .ready_i (unlock_ready),
    .valid_o (unlock_valid),
    .idx_o   (unlock_wid)
  );

endmodule

// File: tb/tb_vx_decode_sched_tracker.sv
// tb/tb_vx_decode_sched_tracker.sv - directed self-checking bench for vx_decode_sched_tracker
module tb_vx_decode_sched_tracker;
  import vx_decode_sched_tracker_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] in_valid;
  logic [3:0] in_wid;
  logic [1:0] in_stall;
  logic [1:0] in_unlock;
  logic [1:0] in_rvc;
  logic [3:0] in_next_state;
  logic [3:0] stalled_mask;
  logic [3:0] rvc_mask;
  logic [7:0] warp_state;
  logic       unlock_valid;
  logic [1:0] unlock_wid;
  logic       unlock_ready;
  logic       err_overflow;
  logic       err_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  vx_decode_sched_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_wid        (in_wid),
    .in_stall      (in_stall),
    .in_unlock     (in_unlock),
    .in_rvc        (in_rvc),
    .in_next_state (in_next_state),
    .stalled_mask  (stalled_mask),
    .rvc_mask      (rvc_mask),
    .warp_state    (warp_state),
    .unlock_valid  (unlock_valid),
    .unlock_wid    (unlock_wid),
    .unlock_ready  (unlock_ready),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle();
    in_valid      = '0;
    in_wid        = '0;
    in_stall      = '0;
    in_unlock     = '0;
    in_rvc        = '0;
    in_next_state = '0;
  endtask

  task automatic set_lane(input int c, input logic [1:0] wid, input logic stall,
                          input logic unlock, input logic rvc, input logic [1:0] ns);
    in_valid[c]          = 1'b1;
    in_wid[c*2 +: 2]     = wid;
    in_stall[c]          = stall;
    in_unlock[c]         = unlock;
    in_rvc[c]            = rvc;
    in_next_state[c*2 +: 2] = ns;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    reset        = 1'b0;
    unlock_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stalled", 32'(stalled_mask), 32'h0);
    check_eq("rst_rvc",     32'(rvc_mask),     32'h0);
    check_eq("rst_state",   32'(warp_state),   32'h0);
    check_eq("rst_uvalid",  32'(unlock_valid), 32'h0);
    check_eq("rst_uwid",    32'(unlock_wid),   32'h0);
    check_eq("rst_errs",    32'({err_overflow, err_underflow}), 32'h0);
    reset = 1'b1;

    // single stall / unlock on w2
    set_lane(0, 2'd2, 1, 0, 0, WS_ACTIVE); step();
    check_eq("stall_w2_mask", 32'(stalled_mask), 32'h4);
    check_eq("stall_w2_uv",   32'(unlock_valid), 32'h0);
    set_lane(1, 2'd2, 0, 1, 0, WS_ACTIVE); step();
    check_eq("unl_w2_mask", 32'(stalled_mask), 32'h0);
    check_eq("unl_w2_uv",   32'(unlock_valid), 32'h1);
    check_eq("unl_w2_wid",  32'(unlock_wid),   32'h2);
    step();
    check_eq("unl_w2_hold_uv",  32'(unlock_valid), 32'h1);
    check_eq("unl_w2_hold_wid", 32'(unlock_wid),   32'h2);
    unlock_ready = 1'b1; step(); unlock_ready = 1'b0;
    check_eq("unl_w2_taken", 32'(unlock_valid), 32'h0);

    // lane with valid low is ignored
    in_wid[1:0] = 2'd1; in_stall[0] = 1'b1; step();
    check_eq("invalid_lane", 32'(stalled_mask), 32'h0);

    // simultaneous stall+unlock on w1, then double unlock at count 2
    set_lane(0, 2'd1, 1, 0, 0, WS_ACTIVE); step();
    check_eq("w1_cnt1", 32'(stalled_mask), 32'h2);
    set_lane(0, 2'd1, 1, 0, 0, WS_ACTIVE); set_lane(1, 2'd1, 0, 1, 0, WS_ACTIVE); step();
    check_eq("w1_net0_mask", 32'(stalled_mask), 32'h2);
    check_eq("w1_net0_uv",   32'(unlock_valid), 32'h0);
    set_lane(0, 2'd1, 1, 0, 0, WS_ACTIVE); step();
    set_lane(0, 2'd1, 0, 1, 0, WS_ACTIVE); set_lane(1, 2'd1, 0, 1, 0, WS_ACTIVE); step();
    check_eq("w1_dbl_mask", 32'(stalled_mask), 32'h0);
    check_eq("w1_dbl_uv",   32'(unlock_valid), 32'h1);
    check_eq("w1_dbl_wid",  32'(unlock_wid),   32'h1);
    unlock_ready = 1'b1; step(); unlock_ready = 1'b0;
    check_eq("w1_one_notify", 32'(unlock_valid),  32'h0);
    check_eq("w1_no_udf",     32'(err_underflow), 32'h0);

    // saturation on w0
    repeat (3) begin set_lane(0, 2'd0, 1, 0, 0, WS_ACTIVE); step(); end
    check_eq("w0_cnt3_mask", 32'(stalled_mask), 32'h1);
    check_eq("w0_cnt3_ovf",  32'(err_overflow), 32'h0);
    set_lane(0, 2'd0, 1, 0, 0, WS_ACTIVE); step();
    check_eq("w0_sat_ovf",  32'(err_overflow), 32'h1);
    set_lane(0, 2'd0, 0, 1, 0, WS_ACTIVE); set_lane(1, 2'd0, 0, 1, 0, WS_ACTIVE); step();
    check_eq("w0_cnt1_mask", 32'(stalled_mask), 32'h1);
    set_lane(0, 2'd0, 0, 1, 0, WS_ACTIVE); step();
    check_eq("w0_cnt0_mask", 32'(stalled_mask), 32'h0);
    check_eq("w0_cnt0_wid",  32'(unlock_wid),   32'h0);
    check_eq("w0_cnt0_uv",   32'(unlock_valid), 32'h1);
    unlock_ready = 1'b1; step(); unlock_ready = 1'b0;
    set_lane(0, 2'd3, 0, 1, 0, WS_ACTIVE); step();
    check_eq("w3_udf",        32'(err_underflow), 32'h1);
    check_eq("w3_udf_no_uv",  32'(unlock_valid),  32'h0);
    check_eq("ovf_sticky",    32'(err_overflow),  32'h1);

    // reset mid-operation drops pending and errors
    set_lane(0, 2'd2, 1, 0, 0, WS_ACTIVE); step();
    set_lane(0, 2'd2, 0, 1, 0, WS_ACTIVE); step();
    check_eq("pre_rst_uv", 32'(unlock_valid), 32'h1);
    reset = 1'b0; #2;
    check_eq("mid_rst_uv",   32'(unlock_valid), 32'h0);
    check_eq("mid_rst_errs", 32'({err_overflow, err_underflow}), 32'h0);
    step(); reset = 1'b1;

    // round-robin: w0,w1 then w3 pending, ready low for 2 clks
    set_lane(0, 2'd0, 1, 0, 0, WS_ACTIVE); set_lane(1, 2'd1, 1, 0, 0, WS_ACTIVE); step();
    set_lane(0, 2'd3, 1, 0, 0, WS_ACTIVE); step();
    check_eq("rr_mask", 32'(stalled_mask), 32'hB);
    set_lane(0, 2'd0, 0, 1, 0, WS_ACTIVE); set_lane(1, 2'd1, 0, 1, 0, WS_ACTIVE); step();
    check_eq("rr_wid_a", 32'(unlock_wid), 32'h0);
    set_lane(0, 2'd3, 0, 1, 0, WS_ACTIVE); step();
    check_eq("rr_wid_b", 32'(unlock_wid), 32'h0);
    step(); check_eq("rr_hold1", 32'(unlock_wid), 32'h0);
    step(); check_eq("rr_hold2", 32'(unlock_wid), 32'h0);
    unlock_ready = 1'b1;
    step(); check_eq("rr_seq1", 32'(unlock_wid), 32'h1);
    step(); check_eq("rr_seq3", 32'(unlock_wid), 32'h3);
    step(); check_eq("rr_done", 32'(unlock_valid), 32'h0);
    unlock_ready = 1'b0;

    // lock: w3 offered, w1 arrives nearer the pointer but offer must not move
    set_lane(0, 2'd3, 1, 0, 0, WS_ACTIVE); set_lane(1, 2'd1, 1, 0, 0, WS_ACTIVE); step();
    set_lane(0, 2'd3, 0, 1, 0, WS_ACTIVE); step();
    check_eq("lock_wid3", 32'(unlock_wid), 32'h3);
    set_lane(0, 2'd1, 0, 1, 0, WS_ACTIVE); step();
    check_eq("lock_stay3", 32'(unlock_wid), 32'h3);
    unlock_ready = 1'b1;
    step(); check_eq("lock_next1", 32'(unlock_wid), 32'h1);
    step(); check_eq("lock_done",  32'(unlock_valid), 32'h0);
    unlock_ready = 1'b0;

    // warp state and lane priority
    set_lane(0, 2'd2, 0, 0, 0, WS_EXIT); set_lane(1, 2'd1, 0, 0, 0, WS_BRANCH); step();
    check_eq("ws_exit", 32'(warp_state), 32'h34);
    set_lane(0, 2'd2, 0, 0, 0, WS_ACTIVE); set_lane(1, 2'd1, 0, 0, 0, WS_BARRIER); step();
    check_eq("ws_exit_abs", 32'(warp_state), 32'h38);
    set_lane(0, 2'd0, 0, 0, 0, WS_BRANCH); set_lane(1, 2'd0, 0, 0, 1, WS_BARRIER); step();
    check_eq("prio_rvc1",  32'(rvc_mask),   32'h1);
    check_eq("prio_ws1",   32'(warp_state), 32'h3A);
    set_lane(0, 2'd0, 0, 0, 1, WS_BRANCH); set_lane(1, 2'd0, 0, 0, 0, WS_ACTIVE); step();
    check_eq("prio_rvc0",  32'(rvc_mask),   32'h0);
    check_eq("prio_ws0",   32'(warp_state), 32'h38);
    reset = 1'b0; step(); reset = 1'b1;
    check_eq("ws_after_rst", 32'(warp_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
